// File: rtl/div_round_seq_if.sv
// ---------------------------------------------------------------------------
// div_round_seq_if
// Handshake bundle for the mantissa divide/round sequencer.
//   in_valid/in_ready : operand handshake (a, b, mode travel with it)
//   out_valid/out_ready : result handshake (y, carry, inexact, err)
// master = operand producer / result consumer, slave = the sequencer.
// ---------------------------------------------------------------------------
interface div_round_seq_if #(
  parameter int WIDTH = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             inexact;
  logic             err;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, y, carry, inexact, err
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, y, carry, inexact, err
  );
endinterface

// File: rtl/div_round_seq.sv
// ---------------------------------------------------------------------------
// div_round_seq
// Bit-serial restoring mantissa divider with final rounding at the ULP
// boundary. One quotient bit per cycle, WIDTH cycles, then one rounding
// cycle; the result is held until the consumer takes it.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : div_round_seq_if.slave (operand and result handshakes)
// Operands are fixed point 1.(WIDTH-1); a valid pair satisfies
// b[WIDTH-1]=1 and b <= a < 2b, so the quotient lies in [1,2).
// ---------------------------------------------------------------------------
module div_round_seq #(
  parameter int WIDTH = 28,
  parameter int ULP   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  div_round_seq_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  // One unit in the last kept place, in WIDTH+1 bits so the carry survives.
  localparam logic [WIDTH:0] ULP_INC = {{(WIDTH - ULP){1'b0}}, 1'b1, {ULP{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] q_r;
  logic             mode_r;
  logic             err_q_r;
  logic [WIDTH-1:0] y_r;
  logic             carry_r;
  logic             inexact_r;
  logic             err_r;

  logic             accept_s;
  logic             last_s;
  logic             in_err_s;
  logic [WIDTH:0]   divisor_s;
  logic             ge_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   r_step_s;
  logic             guard_s;
  logic             sticky_s;
  logic             up_s;
  logic [WIDTH-1:0] trunc_s;
  logic [WIDTH:0]   sum_s;

  assign accept_s = bus.in_valid && (state_r == IDLE);
  assign last_s   = (count_r == LAST);

  // Operand precondition check, evaluated on the accept cycle only.
  always_comb begin
    in_err_s = 1'b0;
    if ((bus.b[WIDTH-1] == 1'b0) || (bus.a < bus.b) ||
        ({1'b0, bus.a} >= {bus.b, 1'b0})) begin
      in_err_s = 1'b1;
    end else begin
      in_err_s = 1'b0;
    end
  end

  // One restoring step; the remainder is not shifted after the final bit.
  always_comb begin
    divisor_s = {1'b0, b_r};
    ge_s      = (r_r >= divisor_s);
    diff_s    = r_r;
    r_step_s  = r_r;
    if (ge_s) begin
      diff_s = r_r - divisor_s;
    end else begin
      diff_s = r_r;
    end
    if (last_s) begin
      r_step_s = diff_s;
    end else begin
      r_step_s = {diff_s[WIDTH-1:0], 1'b0};
    end
  end

  // Rounding of the finished quotient; the remainder feeds the sticky bit.
  always_comb begin
    guard_s  = q_r[ULP-1];
    sticky_s = (|q_r[ULP-2:0]) || (r_r != {(WIDTH + 1){1'b0}});
    trunc_s  = {q_r[WIDTH-1:ULP], {ULP{1'b0}}};
    up_s     = 1'b0;
    if (mode_r == 1'b0) begin
      up_s = guard_s && (sticky_s || q_r[ULP]);
    end else begin
      up_s = 1'b0;
    end
    if (up_s) begin
      sum_s = {1'b0, trunc_s} + ULP_INC;
    end else begin
      sum_s = {1'b0, trunc_s};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = ITER;
        end else begin
          state_s = IDLE;
        end
      end
      ITER: begin
        if (last_s) begin
          state_s = ROUND;
        end else begin
          state_s = ITER;
        end
      end
      ROUND: begin
        state_s = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= {CW{1'b0}};
      r_r       <= {(WIDTH + 1){1'b0}};
      b_r       <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      mode_r    <= 1'b0;
      err_q_r   <= 1'b0;
      y_r       <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      inexact_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            r_r     <= {1'b0, bus.a};
            b_r     <= bus.b;
            mode_r  <= bus.mode;
            err_q_r <= in_err_s;
            q_r     <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
          end
        end
        ITER: begin
          // Quotient bits enter at the LSB; after WIDTH steps bit 0 of the
          // first step has reached the MSB.
          q_r <= {q_r[WIDTH-2:0], ge_s};
          r_r <= r_step_s;
          if (!last_s) begin
            count_r <= count_r + CW'(1);
          end
        end
        ROUND: begin
          y_r       <= sum_s[WIDTH-1:0];
          carry_r   <= sum_s[WIDTH];
          inexact_r <= guard_s || sticky_s;
          err_r     <= err_q_r;
        end
        DONE: begin
          y_r <= y_r;
        end
        default: begin
          y_r <= y_r;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state flops.
  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.y         = y_r;
  assign bus.carry     = carry_r;
  assign bus.inexact   = inexact_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_div_round_seq.sv
// ---------------------------------------------------------------------------
// tb_div_round_seq
// Self-checking bench for div_round_seq: a behavioural divide/round model
// (integer division plus round-to-nearest-even on the nibble below the ULP)
// feeds an expectation queue that a negedge compare process checks against.
// ---------------------------------------------------------------------------
module tb_div_round_seq;

  localparam int W   = 28;
  localparam int LAT = 29;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_round_seq_if #(.WIDTH(W)) bus ();

  div_round_seq #(.WIDTH(W), .ULP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] y;
    logic         carry;
    logic         inexact;
    logic         err;
  } res_t;

  typedef struct {
    res_t r;
    int   e0;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact quotient by integer division, then rounding on its
  // low nibble (value in sixteenths of an ULP step).
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    res_t            res;
    longint unsigned num, q, r, low, t, s;
    bit              up;
    res = '0;
    if ((b[W-1] == 1'b0) || (a < b) || (longint'(a) >= 2 * longint'(b))) begin
      res.err = 1'b1;
      return res;
    end
    num = longint'(a) << (W - 1);
    q   = num / b;
    r   = num % b;
    low = q % 16;
    t   = q - low;
    up  = (m == 1'b0) && ((low > 8) || ((low == 8) && ((r != 0) || (((q / 16) % 2) == 1))));
    s   = t + (up ? 64'd16 : 64'd0);
    res.y       = s[W-1:0];
    res.carry   = s[W];
    res.inexact = (low != 0) || (r != 0);
    return res;
  endfunction

  // Compare process: checks in_ready, latency, stability and result values.
  res_t held;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, exp_q.size() == 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result");
        end else begin
          if (!seen) begin
            chk("latency", cyc - exp_q[0].e0, LAT);
            held = '{y: bus.y, carry: bus.carry, inexact: bus.inexact, err: bus.err};
            seen = 1'b1;
          end else begin
            chk("stable_y", bus.y, held.y);
            chk("stable_flags", {bus.carry, bus.inexact, bus.err},
                {held.carry, held.inexact, held.err});
          end
          if (exp_q[0].r.err) begin
            chk("err", bus.err, 1'b1);
          end else begin
            chk("y", bus.y, exp_q[0].r.y);
            chk("carry", bus.carry, exp_q[0].r.carry);
            chk("inexact", bus.inexact, exp_q[0].r.inexact);
            chk("err", bus.err, 1'b0);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    item_t it;
    int    n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.mode     = m;
    @(posedge clk); #1;
    it.r  = model(a, b, m);
    it.e0 = cyc;
    exp_q.push_back(it);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.mode     = 1'($urandom);
  endtask

  // Waits for the result with random busy-time noise on in_valid/out_ready,
  // then back-pressures for 'hold' cycles and consumes.
  task automatic finish_op(input int hold);
    int n;
    n = 0;
    while (!bus.out_valid && n < 60) begin
      bus.out_ready = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got out_valid=0 expected 1");
    end else begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("in_ready_after_release", bus.in_ready, 1'b1);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input int hold);
    accept_op(a, b, m);
    finish_op(hold);
  endtask

  res_t         m0;
  logic [W-1:0] ra, rb;
  longint       span;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;

    // Pin the model to hand-computed values.
    m0 = model(28'h8000000, 28'h8000000, 1'b0);
    chk("model_exact", {m0.y, m0.carry, m0.inexact, m0.err}, {28'h8000000, 3'b000});
    m0 = model(28'hC000000, 28'hA000000, 1'b0);
    chk("model_rne", {m0.y, m0.inexact}, {28'h99999A0, 1'b1});
    m0 = model(28'hC000000, 28'hA000000, 1'b1);
    chk("model_rtz", {m0.y, m0.inexact}, {28'h9999990, 1'b1});
    m0 = model(28'h8000008, 28'h8000000, 1'b0);
    chk("model_tie_keep", {m0.y, m0.inexact}, {28'h8000000, 1'b1});
    m0 = model(28'h8000018, 28'h8000000, 1'b0);
    chk("model_tie_up", {m0.y, m0.inexact}, {28'h8000020, 1'b1});
    m0 = model(28'hFFFFFFF, 28'h8000000, 1'b0);
    chk("model_carry", {m0.y, m0.carry}, {28'h0000000, 1'b1});
    m0 = model(28'hFFFFFFF, 28'h8000000, 1'b1);
    chk("model_carry_rtz", {m0.y, m0.carry}, {28'hFFFFFF0, 1'b0});
    m0 = model(28'h8000000, 28'h4000000, 1'b0);
    chk("model_err", m0.err, 1'b1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_results", {bus.y, bus.carry, bus.inexact, bus.err}, {28'h0, 3'b000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(28'h8000000, 28'h8000000, 1'b0, 0);
    do_op(28'hC000000, 28'hA000000, 1'b0, 1);
    do_op(28'hC000000, 28'hA000000, 1'b1, 0);
    do_op(28'h8000008, 28'h8000000, 1'b0, 0);
    do_op(28'h8000018, 28'h8000000, 1'b0, 2);
    do_op(28'hFFFFFFF, 28'h8000000, 1'b0, 0);
    do_op(28'hFFFFFFF, 28'h8000000, 1'b1, 0);
    do_op(28'h8000000, 28'h4000000, 1'b0, 5);
    do_op(28'h9000000, 28'h9000000, 1'b0, 0);
    do_op(28'h8000000, 28'hC000000, 1'b1, 0);

    // Reset while iterating (count = 10) with a nonzero held result.
    do_op(28'hC000000, 28'hA000000, 1'b0, 0);
    accept_op(28'hFFFFFFF, 28'h8000000, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_results", {bus.y, bus.carry, bus.inexact, bus.err}, {28'h0, 3'b000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(28'h8000018, 28'h8000000, 1'b0, 1);

    // Randomized operands: mostly legal pairs, some tie patterns, some junk.
    for (int i = 0; i < 60; i++) begin
      rb = {1'b1, 27'($urandom)};
      span = (longint'(rb) < (64'd1 << W) - longint'(rb)) ? longint'(rb)
                                                           : (64'd1 << W) - longint'(rb);
      ra = W'(longint'(rb) + (longint'($urandom) % span));
      case ($urandom_range(0, 4))
        0: begin
          rb = 28'h8000000;
          ra = {1'b1, 23'($urandom), 4'h8};
        end
        1: begin
          ra = W'($urandom);
          rb = W'($urandom);
        end
        default: begin
          ra = ra;
        end
      endcase
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
